detect_event_logger: RTL and testbench
======================================

Name: detect_event_logger

Overview:
- Downstream consumer of the overlapping Moore sequence detector's one-cycle `detected` output.
- Timestamps every detection and queues it in a small first-word-fall-through FIFO for a valid/ready reader, such as a UART or debug bus bridge.
- Maintains a saturating total-detection counter and a sticky overflow flag.
- Lets software or a bench read the exact cycle of each match without sampling `detected` every cycle.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of ev_ts.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- CNT_W, 8, width of the saturating detection counter ev_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- detected  in  1  detector output; each cycle it is high is one event.
- clr  in  1  synchronous clear of FIFO, ev_count and overflow.
- ev_ready  in  1  reader accepts head entry this cycle.
- ev_valid  out  1  FIFO non-empty; ev_ts is valid.
- ev_ts  out  TS_W  timestamp of the oldest queued event.
- ev_count  out  CNT_W  total detections since reset/clr, saturating.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- full  out  1  FIFO holds DEPTH entries.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ts, FIFO pointers and occupancy, ev_count and overflow all go to 0 immediately.
  - Outputs immediately: ev_valid=0, ev_ts=0, full=0.
  - Reset mid-operation discards all queued entries.
- Timestamp:
  - ts increments by 1 every cycle when reset_n=1.
  - Wraps modulo 2^TS_W.
  - Not affected by clr.
  - First cycle after reset release has ts=0.
- Push:
  - Condition: detected=1 at a rising edge where the current ts=T.
  - Writes T into the FIFO tail.
  - If the FIFO was empty, ev_valid=1 with ev_ts=T from the next cycle. Latency is 1 cycle.
- Pop:
  - Condition: ev_valid && ev_ready at a rising edge.
  - Head advances; ev_ts shows the next entry, or 0 when empty, the following cycle.
  - ev_ready while ev_valid=0 is ignored.
- Full and push:
  - Full with no pop: the push is dropped, overflow←1 (sticky), FIFO unchanged.
  - Full with a pop in the same cycle: the push is accepted, occupancy stays DEPTH, no overflow.
- Empty with push in the same cycle:
  - The entry is written; the pop is ignored because ev_valid was 0.
  - ev_valid=1 the next cycle.
- ev_count:
  - +1 for each cycle with detected=1, including dropped events.
  - Saturates at 2^CNT_W−1 and does not wrap.
- clr:
  - Highest priority after reset.
  - Empties the FIFO and zeroes ev_count and overflow at the edge.
  - A concurrent detected or pop is ignored.
- full = (occupancy==DEPTH).
  - Occupancy is held in a log2(DEPTH)+1-bit counter; pointers wrap modulo DEPTH.
- No internal FSM beyond the FIFO. The write/read pointer pair plus the occupancy counter are the state.
  - Legal occupancy is 0..DEPTH.
  - Occupancy changes by +1 (push only), −1 (pop only) or 0 (both or neither).

Decomposition:
- Package detect_log_pkg:
  - Default constants TS_W_DEF=16, DEPTH_DEF=4, CNT_W_DEF=8.
  - A localparam function for clog2.
  - typedef ts_t (logic [TS_W_DEF-1:0]).
- One sub-module, event_fifo:
  - Synchronous FWFT FIFO, parameterised by width and depth.
  - Ports: clk, reset_n, clr, push, wdata, pop, rdata, empty, full.
- The top holds the ts counter, ev_count saturation, the overflow flag and the push/pop qualification.

Test Plan:
1. Hold reset_n=0, drive detected=1 → ev_valid=0, ev_ts=0, ev_count=0, overflow=0, full=0. Release reset; ts reads 0 on the first cycle.
2. Single pulse at ts=5 with ev_ready=0 → at ts=6, ev_valid=1, ev_ts=5, ev_count=1. Raise ev_ready for one cycle → ev_valid=0 next cycle.
3. Drive the detector-style pattern (pulses at ts=10,13,20,23,26) with ev_ready=0 → FIFO holds 10,13,20,23, full=1; the 5th pulse is dropped, overflow=1, ev_count=5. Drain → reads 10,13,20,23 in order, then ev_valid=0.
4. With FIFO full, pulse at ts=40 with ev_ready=1 in the same cycle → head popped, 40 appended, overflow stays 0, full stays 1.
5. Wrap and saturation with TS_W=4, CNT_W=3:
   - Pulse at cycle 17 → ev_ts=1.
   - 10 pulses → ev_count=7.
6. clr asserted in the same cycle as detected=1 with 2 entries queued → next cycle ev_valid=0, ev_count=0, overflow=0. Then assert reset_n=0 mid-cycle with entries queued → outputs clear at once, without waiting for a clock edge.

Source files
------------

// File: rtl/detect_log_pkg.sv
// detect_log_pkg: shared constants, types and helpers for the detection
// event logger.
//   TS_W_DEF  / DEPTH_DEF / CNT_W_DEF : default timestamp width, FIFO depth
//                                       and detection-counter width
//   ts_t                              : timestamp type at the default width
//   clog2()                           : ceiling log2, usable in parameter
//                                       expressions
package detect_log_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef logic [TS_W_DEF-1:0] ts_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(4) = 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/detect_event_logger_fifo.sv
// event_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous flush; push and pop are ignored that cycle
//   push, wdata  : write request and data; taken when not full, or when
//                  full and a pop happens in the same cycle
//   pop          : advance the head; ignored while empty
//   rdata        : head entry, or 0 while empty
//   empty, full  : occupancy == 0 / occupancy == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo
  import detect_log_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);

  // A pop while full frees the head slot this same edge, so a concurrent
  // push can reuse it; the write lands on the slot just read out.
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; the empty mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/detect_event_logger.sv
// detect_event_logger: timestamps each cycle of `detected` and queues the
// timestamp for a valid/ready reader.
//   clk, reset_n : clock, asynchronous active-low reset
//   detected     : one event per cycle it is high
//   clr          : synchronous flush of FIFO, ev_count and overflow
//   ev_valid     : head entry available on ev_ts
//   ev_ready     : reader takes the head entry this cycle
//   ev_ts        : timestamp of the oldest queued event (0 when empty)
//   ev_count     : saturating count of detections since reset/clr
//   overflow     : sticky, an event was dropped because the FIFO was full
//   full         : FIFO holds DEPTH entries
//
// Handshake: an entry transfers on a rising edge where ev_valid && ev_ready;
// ev_valid never depends on ev_ready, ev_ts is stable while ev_valid is high
// and not taken, and ev_ready with ev_valid low has no effect.
module detect_event_logger
  import detect_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             detected,
  input  logic             clr,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [TS_W-1:0]  ev_ts,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0] ts;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;

  // Free-running timestamp; clr deliberately leaves it alone so timestamps
  // stay comparable across flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  assign push = detected && !clr;
  assign pop  = ev_valid && ev_ready && !clr;

  event_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (push),
    .wdata   (ts),
    .pop     (pop),
    .rdata   (ev_ts),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ev_valid = !fifo_empty;
  assign full     = fifo_full;

  // Dropped events still count; the counter pins at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_count <= '0;
    end else if (clr) begin
      ev_count <= '0;
    end else if (detected && (ev_count != CNT_MAX)) begin
      ev_count <= ev_count + 1'b1;
    end
  end

  // A push is lost only when full and no pop frees a slot in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle model of the free-running timestamp: at a falling edge it holds the
  // timestamp the DUT will sample on the next rising edge.
  int tb_ts;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_ts <= 0;
    else          tb_ts <= tb_ts + 1;
  end

  // ---------------- DUT 1: default parameters ----------------
  logic        detected;
  logic        clr;
  logic        ev_ready;
  logic        ev_valid;
  logic [15:0] ev_ts;
  logic [7:0]  ev_count;
  logic        overflow;
  logic        full;

  detect_event_logger u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .detected (detected),
    .clr      (clr),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_ts    (ev_ts),
    .ev_count (ev_count),
    .overflow (overflow),
    .full     (full)
  );

  // ---------------- DUT 2: narrow timestamp and counter ----------------
  logic       detected2;
  logic       clr2;
  logic       ev_ready2;
  logic       ev_valid2;
  logic [3:0] ev_ts2;
  logic [2:0] ev_count2;
  logic       overflow2;
  logic       full2;

  detect_event_logger #(
    .TS_W  (4),
    .DEPTH (4),
    .CNT_W (3)
  ) u_dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .detected (detected2),
    .clr      (clr2),
    .ev_ready (ev_ready2),
    .ev_valid (ev_valid2),
    .ev_ts    (ev_ts2),
    .ev_count (ev_count2),
    .overflow (overflow2),
    .full     (full2)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [3:0]  exp_q2[$];
  int          exp_cnt;
  int          exp_ovf;
  int          exp_cnt2;
  int          exp_ovf2;
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ev_valid", ev_valid, (exp_q.size() != 0));
    check("ev_ts", ev_ts, (exp_q.size() != 0) ? exp_q[0] : 16'h0);
    check("full", full, (exp_q.size() == DEPTH));
    check("ev_count", ev_count, exp_cnt);
    check("overflow", overflow, exp_ovf);
    check("ev_valid2", ev_valid2, (exp_q2.size() != 0));
    check("ev_ts2", ev_ts2, (exp_q2.size() != 0) ? exp_q2[0] : 4'h0);
    check("full2", full2, (exp_q2.size() == DEPTH));
    check("ev_count2", ev_count2, exp_cnt2);
    check("overflow2", overflow2, exp_ovf2);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_q2.delete();
    exp_cnt  = 0;
    exp_ovf  = 0;
    exp_cnt2 = 0;
    exp_ovf2 = 0;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives inputs, predicts the effect of the next
  // rising edge, then checks outputs at the following falling edge.
  task automatic step(input logic d, input logic r, input logic c, input logic d2);
    bit   pop_ok;
    bit   was_full;
    logic [15:0] ts16;
    logic [3:0]  ts4;
    detected  = d;
    ev_ready  = r;
    clr       = c;
    detected2 = d2;
    ts16      = tb_ts[15:0];
    ts4       = tb_ts[3:0];

    pop_ok   = !c && r && (exp_q.size() != 0);
    was_full = (exp_q.size() == DEPTH);
    if (pop_ok) check("pop_ts", ev_ts, exp_q[0]);
    if (c) begin
      exp_q.delete();
      exp_cnt = 0;
      exp_ovf = 0;
    end else begin
      if (pop_ok) void'(exp_q.pop_front());
      if (d) begin
        if (exp_cnt < 255) exp_cnt++;
        if (was_full && !pop_ok) exp_ovf = 1;
        else exp_q.push_back(ts16);
      end
    end

    // DUT 2 is never read or cleared here.
    if (d2) begin
      if (exp_cnt2 < 7) exp_cnt2++;
      if (exp_q2.size() == DEPTH) exp_ovf2 = 1;
      else exp_q2.push_back(ts4);
    end

    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    detected  = 1'b1;
    detected2 = 1'b1;
    clr       = 1'b0;
    clr2      = 1'b0;
    ev_ready  = 1'b0;
    ev_ready2 = 1'b0;
    clear_model();

    // Test 1: reset holds everything at zero even with detected high.
    repeat (3) @(negedge clk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_ts", ev_ts, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_full", full, 0);
    check("rst_ev_count2", ev_count2, 0);
    detected  = 1'b0;
    detected2 = 1'b0;
    reset_n   = 1'b1;

    // Test 2: single pulse at ts=5, then one read.
    while (tb_ts < 5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t2_ev_ts", ev_ts, 5);
    check("t2_ev_count", ev_count, 1);
    step(0, 1, 0, 0);
    check("t2_empty_after_pop", ev_valid, 0);

    // Test 3: detector-style burst with the reader stalled.
    step(0, 0, 1, 0);
    while (tb_ts <= 26)
      step((tb_ts == 10) || (tb_ts == 13) || (tb_ts == 20) || (tb_ts == 23) || (tb_ts == 26), 0, 0, 0);
    check("t3_full", full, 1);
    check("t3_overflow", overflow, 1);
    check("t3_ev_count", ev_count, 5);
    check("t3_head", ev_ts, 10);
    repeat (4) step(0, 1, 0, 0);
    check("t3_drained", ev_valid, 0);

    // Test 4: push and pop on the same edge while full.
    step(0, 0, 1, 0);
    repeat (4) step(1, 0, 0, 0);
    while (tb_ts < 40) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("t4_full", full, 1);
    check("t4_overflow", overflow, 0);
    repeat (4) step(0, 1, 0, 0);
    check("t4_tail_ts40", 32'(ev_valid), 0);

    // Test 6: clr with a concurrent detection and two entries queued.
    repeat (5) step(1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    check("t6_ovf_before_clr", overflow, 1);
    step(1, 0, 1, 0);
    check("t6_clr_valid", ev_valid, 0);
    check("t6_clr_count", ev_count, 0);
    check("t6_clr_overflow", overflow, 0);

    // Asynchronous reset between edges with entries queued.
    repeat (3) step(1, 0, 0, 1);
    detected  = 1'b0;
    detected2 = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ev_valid", ev_valid, 0);
    check("arst_ev_ts", ev_ts, 0);
    check("arst_full", full, 0);
    check("arst_ev_count", ev_count, 0);
    check("arst_overflow", overflow, 0);
    check("arst_ev_valid2", ev_valid2, 0);
    check("arst_ev_count2", ev_count2, 0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;

    // Test 5: timestamp wrap and counter saturation on the narrow instance.
    while (tb_ts < 17) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t5_wrap_ts", ev_ts2, 1);
    repeat (10) step(0, 0, 0, 1);
    check("t5_sat_count", ev_count2, 7);
    check("t5_overflow2", overflow2, 1);
    check("t5_head_kept", ev_ts2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
